// File: rtl/worker_cpu_cpu_debug_pkg.sv
// Shared definitions for the JTAG debug memory stage.
// Optional build macro: OCIMEM_PARITY_EN widens the debug RAM by one parity bit.
package worker_cpu_cpu_debug_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_J_RD = 2'd1,
    S_C_RD = 2'd2
  } state_e;

  // Field positions inside the 38-bit JTAG data-out word.
  localparam int JDO_RD_BIT   = 35;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;

`ifdef OCIMEM_PARITY_EN
  localparam int RAM_W = 33;
`else
  localparam int RAM_W = 32;
`endif

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/worker_cpu_cpu_ociram_sp_ram.sv
// Single-port on-chip debug RAM, synchronous read, byte-lane writes.
// With OCIMEM_PARITY_EN defined the word carries an extra even-parity bit
// (bit 32) recomputed from the merged word on every write.
module worker_cpu_cpu_ociram_sp_ram
  import worker_cpu_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ren,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [RAM_W-1:0]  q
);

  logic [RAM_W-1:0] mem [2**ADDR_W];

`ifdef OCIMEM_PARITY_EN
  logic [31:0] merged;

  // Word as it will look after this write, so parity covers untouched lanes too.
  always_comb begin
    merged = mem[addr][31:0];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end
`endif

  // Byte-lane write and registered read of the addressed word.
  // NOTE: the array and its read register have no reset; contents must survive a debug reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
`ifdef OCIMEM_PARITY_EN
      mem[addr][32] <= even_parity(merged);
`endif
    end
    if (ren) q <= mem[addr];
  end

endmodule

// File: rtl/worker_cpu_cpu_debug_ocimem.sv
// JTAG debug memory stage: owns the debug RAM, serves JTAG monitor
// read/write commands and a debugaccess-gated CPU Avalon slave on one port.
// JTAG work always wins the RAM port over a CPU request.
// Optional build macro: OCIMEM_PARITY_EN (parity-checked RAM, monitor_error live).
module worker_cpu_cpu_debug_ocimem
  import worker_cpu_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e            state;
  logic [ADDR_W-1:0] mon_areg;
  logic              rd_pend;
  logic              wr_pend;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ren;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [RAM_W-1:0]  ram_q;
  logic              cpu_done;

  // Reserved jdo bits this stage never looks at.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // RAM port arbitration: pending JTAG write, pending JTAG read, then CPU.
  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    ram_addr  = mon_areg;
    ram_ren   = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = MonDReg;
    cpu_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wr_pend) begin
          ram_we = 1'b1;
        end else if (rd_pend) begin
          ram_ren = 1'b1;
        end else if (read && debugaccess) begin
          ram_addr = address;
          ram_ren  = 1'b1;
        end else if (write && debugaccess) begin
          ram_addr  = address;
          ram_we    = 1'b1;
          ram_be    = byteenable;
          ram_wdata = writedata;
          cpu_done  = 1'b1;
        end
      end
      S_C_RD:  cpu_done = 1'b1;
      default: cpu_done = 1'b0;
    endcase
    // Ungated requests are acknowledged at once and never touch the RAM.
    if ((read || write) && !debugaccess) cpu_done = 1'b1;
  end

  assign waitrequest = (read | write) & ~cpu_done;
  assign readdata    = (state == S_C_RD) ? ram_q[31:0] : 32'd0;

  worker_cpu_cpu_ociram_sp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .ren   (ram_ren),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // FSM and monitor registers; JTAG strobes are applied last so a new command overrides the FSM.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      mon_areg      <= '0;
      MonDReg       <= '0;
      rd_pend       <= 1'b0;
      wr_pend       <= 1'b0;
      monitor_ready <= 1'b0;
`ifdef OCIMEM_PARITY_EN
      monitor_error <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (wr_pend) begin
            wr_pend  <= 1'b0;
            mon_areg <= mon_areg + 1'b1;
          end else if (rd_pend) begin
            rd_pend <= 1'b0;
            state   <= S_J_RD;
          end else if (read && debugaccess) begin
            state <= S_C_RD;
          end
        end
        S_J_RD: begin
          MonDReg       <= ram_q[31:0];
          monitor_ready <= 1'b1;
`ifdef OCIMEM_PARITY_EN
          monitor_error <= ram_q[32] ^ even_parity(ram_q[31:0]);
`endif
          state         <= S_IDLE;
        end
        S_C_RD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (take_action_ocimem_b) begin
        MonDReg <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        wr_pend <= 1'b1;
        rd_pend <= 1'b0;
      end else if (take_action_ocimem_a) begin
        mon_areg <= jdo[JDO_ADDR_LSB +: ADDR_W];
`ifdef OCIMEM_PARITY_EN
        monitor_error <= 1'b0;
`endif
        if (jdo[JDO_RD_BIT]) begin
          rd_pend       <= 1'b1;
          wr_pend       <= 1'b0;
          monitor_ready <= 1'b0;
        end
      end else if (take_no_action_ocimem_a) begin
        mon_areg      <= mon_areg + 1'b1;
        rd_pend       <= 1'b1;
        wr_pend       <= 1'b0;
        monitor_ready <= 1'b0;
      end
    end
  end

`ifndef OCIMEM_PARITY_EN
  assign monitor_error = 1'b0;
`endif

endmodule

// File: tb/tb_worker_cpu_cpu_debug_ocimem.sv
// Self-checking bench for worker_cpu_cpu_debug_ocimem.
// A transaction-level model (word array + expected monitor registers) is
// updated by the stimulus tasks; one negedge process compares the monitor
// outputs every cycle, and directed literals pin the model.
// Build with +define+OCIMEM_PARITY_EN to include the parity scenario.
module tb_worker_cpu_cpu_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic [31:0] m_mem [256];
  bit          m_bad [256];
  logic [7:0]  m_areg = '0;
  logic [31:0] exp_dreg = '0;
  logic        exp_ready = 1'b0;
  logic        exp_err = 1'b0;
  bit          chk_on = 1'b0;
  logic [31:0] pend_data;
  logic        pend_err;

  worker_cpu_cpu_debug_ocimem #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous comparison of the monitor interface against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("mon_dreg", MonDReg, exp_dreg);
      check("mon_ready", 32'(monitor_ready), 32'(exp_ready));
      check("mon_error", 32'(monitor_error), 32'(exp_err));
      if (!read) check("readdata_idle", readdata, 32'd0);
      if (!read && !write) check("wait_idle", 32'(waitrequest), 32'd0);
    end
  end

  function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd);
    logic [37:0] v;
    v = '0;
    v[35] = rd;
    v[17 +: 8] = a;
    return v;
  endfunction

  // Address (and optional read) command; blocks until the read lands.
  task automatic jtag_a(input logic [7:0] a, input logic rd);
    jdo = mk_a(a, rd);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    m_areg  = a;
    exp_err = 1'b0;
    if (rd) begin
      exp_ready = 1'b0;
      tick();
      tick();
      exp_dreg  = m_mem[a];
      exp_ready = 1'b1;
      exp_err   = m_bad[a];
    end
  endtask

  // Write-data command; the RAM write lands one cycle after the strobe.
  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    exp_dreg = d;
    tick();
    m_mem[m_areg] = d;
    m_bad[m_areg] = 1'b0;
    m_areg = m_areg + 8'd1;
  endtask

  // Stream read of the next word.
  task automatic jtag_next();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    m_areg    = m_areg + 8'd1;
    exp_ready = 1'b0;
    tick();
    tick();
    exp_dreg  = m_mem[m_areg];
    exp_ready = 1'b1;
    exp_err   = m_bad[m_areg];
  endtask

  task automatic cpu_read(input string nm, input logic [7:0] a, input logic da,
                          input logic [31:0] exp, input int exp_waits);
    int n;
    bit done;
    logic [31:0] got;
    address = a;
    debugaccess = da;
    read = 1'b1;
    n = 0;
    done = 1'b0;
    got = 'x;
    while (!done && n < 20) begin
      @(negedge clk);
      if (!waitrequest) begin
        got  = readdata;
        done = 1'b1;
      end else begin
        n++;
      end
      tick();
    end
    read = 1'b0;
    debugaccess = 1'b0;
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_data"}, got, exp);
    check({nm, "_waits"}, 32'(n), 32'(exp_waits));
  endtask

  task automatic cpu_write(input string nm, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic da);
    address = a;
    writedata = d;
    byteenable = be;
    debugaccess = da;
    write = 1'b1;
    @(negedge clk);
    check({nm, "_wait"}, 32'(waitrequest), 32'd0);
    tick();
    write = 1'b0;
    debugaccess = 1'b0;
    if (da) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
      end
      m_bad[a] = 1'b0;
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) tick();
    check("rst_wait", 32'(waitrequest), 32'd0);
    check("rst_mondreg", MonDReg, 32'd0);
    reset_n = 1'b1;
    tick();

    // JTAG write then read back through the monitor.
    jtag_a(8'h10, 1'b0);
    jtag_b(32'hDEADBEEF);
    cpu_read("rd_0x10", 8'h10, 1'b1, 32'hDEADBEEF, 1);
    jtag_b(32'hCAFEF00D);  // lands at the auto-incremented address 0x11
    cpu_read("rd_0x11", 8'h11, 1'b1, 32'hCAFEF00D, 1);
    jtag_a(8'h10, 1'b1);
    check("jrd_lit_dreg", MonDReg, 32'hDEADBEEF);
    check("jrd_lit_ready", 32'(monitor_ready), 32'd1);

    // Write increment and stream read both wrap 0xFF -> 0x00.
    jtag_a(8'hFF, 1'b0);
    jtag_b(32'h000000A5);
    jtag_b(32'h0000005A);
    jtag_a(8'hFF, 1'b1);
    check("stream_lit_ff", MonDReg, 32'h000000A5);
    jtag_next();
    check("stream_lit_00", MonDReg, 32'h0000005A);

    // Gating and byte lanes.
    cpu_write("wr30_init", 8'h30, 32'h11111111, 4'hF, 1'b1);
    cpu_write("wr30_gated", 8'h30, 32'h00001234, 4'hF, 1'b0);
    cpu_read("rd30_gated", 8'h30, 1'b1, 32'h11111111, 1);
    cpu_read("rd_nogate", 8'h30, 1'b0, 32'd0, 0);
    cpu_write("wr30_be", 8'h30, 32'hAABBCCDD, 4'b0010, 1'b1);
    cpu_read("rd30_be", 8'h30, 1'b1, 32'h1111CC11, 1);
    cpu_write("wr40_both", 8'h40, 32'h0F0F0F0F, 4'hF, 1'b1);

    // Conflict: CPU read raised while the JTAG read is pending.
    cpu_write("wr20", 8'h20, 32'h20202020, 4'hF, 1'b1);
    jdo = mk_a(8'h10, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    m_areg = 8'h10;
    exp_ready = 1'b0;
    exp_err = 1'b0;
    pend_data = m_mem[8'h10];
    pend_err = m_bad[8'h10];
    fork
      begin
        tick();
        tick();
        exp_dreg  = pend_data;
        exp_ready = 1'b1;
        exp_err   = pend_err;
      end
    join_none
    cpu_read("conflict", 8'h20, 1'b1, 32'h20202020, 3);
    check("conflict_lit_dreg", MonDReg, 32'hDEADBEEF);

    // Reset in the middle of a JTAG read.
    jtag_a(8'h50, 1'b0);
    jtag_b(32'h0BADF00D);
    jdo = mk_a(8'h50, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    exp_ready = 1'b0;
    tick();
    reset_n   = 1'b0;
    exp_dreg  = '0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    m_areg    = '0;
    #1;
    check("rst_mid_dreg", MonDReg, 32'd0);
    check("rst_mid_ready", 32'(monitor_ready), 32'd0);
    check("rst_mid_rdata", readdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_mid_ready_after", 32'(monitor_ready), 32'd0);
    cpu_read("rd_after_rst", 8'h50, 1'b1, 32'h0BADF00D, 1);
    jtag_b(32'h600DCAFE);  // address register restarted at 0
    cpu_read("rd_0_after_rst", 8'h00, 1'b1, 32'h600DCAFE, 1);
    cpu_read("rd_11_kept", 8'h11, 1'b1, 32'hCAFEF00D, 1);

`ifdef OCIMEM_PARITY_EN
    jtag_a(8'h40, 1'b0);
    jtag_b(32'h12345678);
    @(negedge clk);
    dut.u_ram.mem[8'h40][32] = ~dut.u_ram.mem[8'h40][32];
    m_bad[8'h40] = 1'b1;
    tick();
    jtag_a(8'h40, 1'b1);
    check("par_lit_err", 32'(monitor_error), 32'd1);
    check("par_lit_dreg", MonDReg, 32'h12345678);
    cpu_read("par_cpu_rd", 8'h40, 1'b1, 32'h12345678, 1);
    jtag_a(8'h00, 1'b0);
    check("par_lit_clear", 32'(monitor_error), 32'd0);
`endif

    tick();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
